// File: rtl/shared_adder_sched_pkg.sv
// shared_adder_sched_pkg: op codes and FSM state encoding shared by the scheduler files
package shared_adder_sched_pkg;
  localparam logic OP_SUM = 1'b0;
  localparam logic OP_INC = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/shared_adder_sched_if.sv
// shared_adder_sched_if: requester bus (master drives req/op/a/b, slave returns gnt/c/carry/done/done_id)
interface shared_adder_sched_if #(parameter int NREQ = 4, parameter int WIDTH = 8);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] op;
  logic [NREQ*WIDTH-1:0] a;
  logic [NREQ*WIDTH-1:0] b;
  logic [NREQ-1:0] gnt;
  logic [WIDTH-1:0] c;
  logic carry;
  logic done;
  logic [IDW-1:0] done_id;
  modport master (output req, op, a, b, input gnt, c, carry, done, done_id);
  modport slave (input req, op, a, b, output gnt, c, carry, done, done_id);
endinterface

// File: rtl/shared_adder_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (req, ptr in; any_req, win_idx, one-hot win_oh out)
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any_req,
  output logic [IDW-1:0]  win_idx,
  output logic [NREQ-1:0] win_oh
);
  always_comb begin
    any_req = |req;
    win_idx = '0;
    win_oh = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        win_idx = IDW'((int'(ptr) + i) % NREQ);
        win_oh = NREQ'(1) << ((int'(ptr) + i) % NREQ);
      end
    end
  end
endmodule

// File: rtl/shared_adder_sched.sv
// shared_adder_sched: round-robin share of one add/increment datapath (clk, rst, slave bus of req/op/a/b -> gnt/c/carry/done/done_id)
module shared_adder_sched
  import shared_adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(NREQ)
) (
  input logic clk,
  input logic rst,
  shared_adder_sched_if.slave bus
);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, win_idx;
  logic [NREQ-1:0] gnt_q, gnt_d, win_oh;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic op_q, op_d, carry_q, carry_d, any_req, grab;
  logic [WIDTH:0] sum;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(bus.req),
    .ptr(ptr_q),
    .any_req(any_req),
    .win_idx(win_idx),
    .win_oh(win_oh)
  );
  always_comb begin
    grab = state_q == IDLE && any_req;
    state_d = state_q == IDLE ? (any_req ? EXEC : IDLE) : state_q == EXEC ? RESP : IDLE;
    ptr_d = grab ? (win_idx == IDW'(NREQ - 1) ? '0 : win_idx + 1'b1) : ptr_q;
    gnt_d = grab ? win_oh : '0;
    id_d = grab ? win_idx : id_q;
    op_d = grab ? bus.op[win_idx] : op_q;
    a_d = grab ? bus.a[win_idx*WIDTH +: WIDTH] : a_q;
    b_d = grab ? bus.b[win_idx*WIDTH +: WIDTH] : b_q;
    sum = {1'b0, a_q} + (op_q == OP_INC ? (WIDTH+1)'(1) : {1'b0, b_q});
    {carry_d, c_d} = state_q == EXEC ? sum : {carry_q, c_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      id_q <= '0;
      op_q <= OP_SUM;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      id_q <= id_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      carry_q <= carry_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.done = state_q == RESP;
  assign bus.c = c_q;
  assign bus.carry = carry_q;
  assign bus.done_id = id_q;
endmodule

// File: doc/shared_adder_sched.md
# shared_adder_sched

Round-robin scheduler that shares a single WIDTH-bit add/increment datapath between NREQ requesters. Each requester presents an operation (sum a+b, or increment a) with its operands. The block grants one requester at a time, latches its operands, and computes on the shared adder. It returns a registered result with carry, tagged with the requester index. It sits between the client blocks that need sum/increment service and the single adder instance, so there is no per-client adder.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width
- IDW, $clog2(NREQ), requester-index width (derived, not overridden)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  request per requester; level, held until granted
- op  input  NREQ  per-requester op: 0 = sum (a+b), 1 = increment (a+1)
- a  input  NREQ*WIDTH  packed operand a; requester i at [i*WIDTH +: WIDTH]
- b  input  NREQ*WIDTH  packed operand b; ignored for increment
- gnt  output  NREQ  one-hot grant pulse, one cycle
- c  output  WIDTH  result, low WIDTH bits of the sum
- carry  output  1  bit WIDTH of the sum
- done  output  1  result-valid pulse, one cycle
- done_id  output  IDW  index of the requester the current result belongs to

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req bit is set, pick the winner by round-robin and go to EXEC. Otherwise stay in IDLE.
- Round-robin search starts at pointer ptr and wraps from NREQ-1 to 0. The winner is the first set req at or after ptr.
- On the IDLE→EXEC edge:
  - register gnt = one-hot(winner);
  - latch op, a and b of the winner, and latch winner into done_id;
  - set ptr = winner+1, wrapping to 0 after NREQ-1.
- EXEC: gnt is high for exactly this cycle. The adder computes; {carry,c} is registered on the EXEC→RESP edge.
- RESP: done = 1 for one cycle, then go to IDLE.
- Arbitration happens in IDLE only. req changes during EXEC or RESP are ignored until the next IDLE.
- Requester contract: keep req, op and operands stable until gnt is seen, then drop req in the following cycle. A req still high when the FSM returns to IDLE is treated as a new request.
- Arithmetic: sum = {1'b0,a}+{1'b0,b}, WIDTH+1 bits; increment = {1'b0,a}+1. c = sum[WIDTH-1:0], carry = sum[WIDTH].
- Wrap-around: increment of all-ones gives c=0, carry=1. Sum 0xFF+0x01 at WIDTH=8 gives c=0x00, carry=1.
- c, carry and done_id hold their values until the next RESP. They are valid only while done=1.

## Timing
- Reset (rst=1 at an edge): state=IDLE, ptr=0, gnt=0, done=0, c=0, carry=0, done_id=0.
- Reset mid-operation aborts the transaction. No done is produced for it.
- Latency: req sampled in IDLE at edge t → gnt high in cycle t+1 → done high in cycle t+2.
- Throughput: one operation per 3 cycles. With requests back-to-back, the next grant follows the cycle after RESP.
- Simultaneous requests: exactly one grant per transaction. After requester k is served, k has the lowest priority.
- gnt and done are never high in the same cycle.

## Structure
- Shared package: OP_SUM=1'b0 and OP_INC=1'b1 constants, plus the FSM state typedef/encoding (IDLE, EXEC, RESP).
- One sub-module, rr_arbiter: a combinational round-robin pick.
  - Inputs: req, ptr.
  - Outputs: any_req, winner index, one-hot winner.
  - The FSM, ptr register, operand latch and adder stay in the top level.

## Test plan
- Single request: requester 2, op=0, a=7, b=4 → gnt=4'b0100 one cycle, then done=1, c=11, carry=0, done_id=2.
- Increment with wrap: requester 0, op=1, a=0xFF → c=0x00, carry=1. Also a=6 → c=7, carry=0.
- All four req held high with each requester dropping req after its gnt → grants in order 0,1,2,3. Then req0 again → grant 0. Each done_id matches the preceding gnt.
- Fairness: req1 and req3 both held continuously → grants alternate 1,3,1,3. A requester is never granted twice in a row while the other is waiting.
- Reset in EXEC after a grant → no done pulse; outputs return to 0; ptr=0. The next request from requester 3 is granted normally.
- Operand changes after gnt (a and b altered during EXEC) → result still reflects the latched values, e.g. 0x80+0x80 gives c=0x00, carry=1.
